bcd_decade_counter: RTL and testbench



---
 rtl/bcd_decade_counter_pkg.sv | 6 +
 rtl/bcd_decade_counter_jk_ff.sv | 29 ++
 rtl/bcd_decade_counter.sv | 46 ++++
 tb/tb_bcd_decade_counter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_decade_counter_pkg.sv
// Shared constants and types for the BCD decade counter.
package bcd_decade_counter_pkg;
   localparam logic [3:0] DECADE_MAX   = 4'd9;
   localparam logic [3:0] DECADE_RESET = 4'd0;
   typedef logic [3:0] bcd_t;
endpackage

// File: rtl/bcd_decade_counter_jk_ff.sv
// JK flip-flop: hold 00, reset 01, set 10, toggle 11; async active-high reset.
module jk_ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);
   logic q_q, q_d;

   always_comb begin
      q_d = q_q;
      case ({j, k})
         2'b01:   q_d = 1'b0;
         2'b10:   q_d = 1'b1;
         2'b11:   q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= RST_VAL;
      else     q_q <= q_d;
   end

   assign q = q_q;
endmodule

// File: rtl/bcd_decade_counter.sv
// Self-correcting 0..9 decade counter built from four JK flops; z is the
// same-cycle carry into the next digit.
module bcd_decade_counter
   import bcd_decade_counter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   input  logic x,
   output logic z
);
   bcd_t       q;
   logic [3:0] j, k;
   logic       ill;

   // Excitation from the next-state table; states 10..15 all drive toward 0.
   always_comb begin
      j    = '0;
      k    = '0;
      ill  = q[3] & (q[2] | q[1]);
      j[0] = x & ~ill;
      k[0] = x | ill;
      j[1] = x & q[0] & ~q[3];
      k[1] = (x & q[0]) | q[3];
      j[2] = x & q[1] & q[0] & ~q[3];
      k[2] = (x & q[1] & q[0]) | q[3];
      j[3] = x & q[2] & q[1] & q[0];
      k[3] = (x & q[0]) | q[2] | q[1];
   end

   for (genvar i = 0; i < 4; i++) begin : g_bit
      jk_ff #(.RST_VAL(DECADE_RESET[i])) u_ff (
         .clk (clk),
         .rst (rst),
         .j   (j[i]),
         .k   (k[i]),
         .q   (q[i])
      );
   end

   assign {a, b, c, d} = q;
   assign z = x & (q == DECADE_MAX);
endmodule

// File: tb/tb_bcd_decade_counter.sv
// Randomized and directed checks of bcd_decade_counter, cascaded as two digits.
module tb_bcd_decade_counter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic x   = 1'b0;
   logic a0, b0, c0, d0, z0;
   logic a1, b1, c1, d1, z1;
   int   total = 0;
   int   bad   = 0;
   int   lo_m  = 0;
   int   hi_m  = 0;

   always #5 clk = ~clk;

   bcd_decade_counter dut (
      .clk(clk), .rst(rst), .a(a0), .b(b0), .c(c0), .d(d0), .x(x), .z(z0)
   );
   bcd_decade_counter dut_hi (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1), .x(z0), .z(z1)
   );

   function automatic int mdl_next(input int q, input bit en);
      if (q > 9) return 0;
      if (en)    return (q + 1) % 10;
      return q;
   endfunction

   function automatic bit mdl_z(input int q, input bit en);
      return en && (q == 9);
   endfunction

   function automatic int qlo();
      return int'({a0, b0, c0, d0});
   endfunction

   function automatic int qhi();
      return int'({a1, b1, c1, d1});
   endfunction

   task automatic tick();
      bit zl;
      zl = mdl_z(lo_m, x);
      @(posedge clk);
      if (rst) begin
         lo_m = 0;
         hi_m = 0;
      end else begin
         lo_m = mdl_next(lo_m, x);
         hi_m = mdl_next(hi_m, zl);
      end
      #1;
   endtask

   task automatic force_lo(input logic [3:0] v);
      @(negedge clk);
      force dut.g_bit[3].u_ff.q_q = v[3];
      force dut.g_bit[2].u_ff.q_q = v[2];
      force dut.g_bit[1].u_ff.q_q = v[1];
      force dut.g_bit[0].u_ff.q_q = v[0];
      #1;
      release dut.g_bit[3].u_ff.q_q;
      release dut.g_bit[2].u_ff.q_q;
      release dut.g_bit[1].u_ff.q_q;
      release dut.g_bit[0].u_ff.q_q;
      lo_m = int'(v);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      x   = 1'b1;
      tick();
      total++;
      if (qlo() !== 0 || z0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: q=%0d z=%b want q=0 z=0", qlo(), z0);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (qlo() !== 5) begin
         bad++;
         $display("FAIL reset_pre5: q=%0d want 5", qlo());
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (qlo() !== 0 || z0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: q=%0d z=%b want q=0 z=0", qlo(), z0);
      end
      lo_m = 0;
      hi_m = 0;
      tick();
      total++;
      if (qlo() !== 0) begin
         bad++;
         $display("FAIL reset_edge_ignored: q=%0d want 0", qlo());
      end
      #2 rst = 1'b0;
      tick();
      total++;
      if (qlo() !== 1) begin
         bad++;
         $display("FAIL reset_resume: q=%0d want 1", qlo());
      end
   endtask

   task automatic test_full_count();
      int exp_seq[12] = '{2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3};
      x = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         total++;
         if (z0 !== mdl_z(lo_m, 1'b1)) begin
            bad++;
            $display("FAIL count_z[%0d]: z=%b want %b", i, z0, mdl_z(lo_m, 1'b1));
         end
         tick();
         total++;
         if (qlo() !== exp_seq[i] || qlo() !== lo_m) begin
            bad++;
            $display("FAIL count_q[%0d]: q=%0d want %0d", i, qlo(), exp_seq[i]);
         end
      end
   endtask

   task automatic test_alternate();
      for (int i = 0; i < 100; i++) begin
         x = i[0];
         tick();
         total++;
         if (qlo() !== lo_m || qlo() > 9) begin
            bad++;
            $display("FAIL alternate[%0d]: q=%0d want %0d", i, qlo(), lo_m);
         end
      end
   endtask

   task automatic test_hold_terminal();
      x = 1'b1;
      while (lo_m != 9) tick();
      x = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (qlo() !== 9 || z0 !== 1'b0) begin
            bad++;
            $display("FAIL hold9[%0d]: q=%0d z=%b want q=9 z=0", i, qlo(), z0);
         end
      end
      x = 1'b1;
      #1;
      total++;
      if (z0 !== 1'b1) begin
         bad++;
         $display("FAIL hold9_carry: z=%b want 1", z0);
      end
      tick();
      total++;
      if (qlo() !== 0 || z0 !== 1'b0) begin
         bad++;
         $display("FAIL hold9_wrap: q=%0d z=%b want q=0 z=0", qlo(), z0);
      end
   endtask

   task automatic test_illegal();
      logic [3:0] pats[4] = '{4'b1100, 4'b1111, 4'b1010, 4'b1101};
      for (int i = 0; i < 4; i++) begin
         x = i[0];
         force_lo(pats[i]);
         total++;
         if (qlo() !== int'(pats[i]) || z0 !== 1'b0) begin
            bad++;
            $display("FAIL illegal_z[%0d]: q=%0d z=%b want q=%0d z=0", i, qlo(), z0, pats[i]);
         end
         tick();
         total++;
         if (qlo() !== 0) begin
            bad++;
            $display("FAIL illegal_recover[%0d]: q=%0d want 0", i, qlo());
         end
      end
   endtask

   task automatic test_cascade();
      #2 rst = 1'b1;
      tick();
      #2 rst = 1'b0;
      x = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         total++;
         if (qlo() !== i % 10 || qhi() !== (i / 10) % 10) begin
            bad++;
            $display("FAIL cascade[%0d]: hi=%0d lo=%0d want hi=%0d lo=%0d",
                     i, qhi(), qlo(), (i / 10) % 10, i % 10);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         x = 1'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            #2 rst = 1'b1;
            #1;
            lo_m = 0;
            hi_m = 0;
            total++;
            if (qlo() !== 0 || qhi() !== 0) begin
               bad++;
               $display("FAIL rand_rst[%0d]: hi=%0d lo=%0d want 0", i, qhi(), qlo());
            end
            tick();
            rst = 1'b0;
         end
         #1;
         total++;
         if (z0 !== mdl_z(lo_m, x)) begin
            bad++;
            $display("FAIL rand_z[%0d]: z=%b want %b", i, z0, mdl_z(lo_m, x));
         end
         tick();
         total++;
         if (qlo() !== lo_m || qhi() !== hi_m) begin
            bad++;
            $display("FAIL rand_q[%0d]: hi=%0d lo=%0d want hi=%0d lo=%0d",
                     i, qhi(), qlo(), hi_m, lo_m);
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_full_count();
      test_alternate();
      test_hold_terminal();
      test_illegal();
      test_cascade();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
